// File: rtl/axis_tensor_loader.sv
// Streams one job (image tensor, then kernel tensor) from two read buffers over AXI-Stream.
// Define AXIS_LOADER_TENSOR_GAP_EN to insert one idle tvalid cycle between the two tensors.
module axis_tensor_loader #(
    parameter int ADDR_WIDTH         = 13,
    parameter int DATA_WIDTH         = 8,
    parameter int NUM_CHANNELS_WIDTH = 7
) (
    input  logic                                        m_axis_aclk,
    input  logic                                        m_axis_areset,
    input  logic                                        start,
    input  logic [ADDR_WIDTH-1:0]                       img_row,
    input  logic [ADDR_WIDTH-1:0]                       img_col,
    input  logic [ADDR_WIDTH-1:0]                       ker_row,
    input  logic [ADDR_WIDTH-1:0]                       ker_col,
    input  logic [NUM_CHANNELS_WIDTH-1:0]               num_channels,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        mem_rd_en,
    output logic                                        mem_rd_sel,
    output logic [ADDR_WIDTH-1:0]                       mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]                       mem_rd_data,
    output logic [DATA_WIDTH-1:0]                       m_axis_tdata,
    output logic                                        m_axis_tvalid,
    input  logic                                        m_axis_tready,
    output logic                                        m_axis_tlast,
    output logic [2*ADDR_WIDTH+NUM_CHANNELS_WIDTH-1:0]  m_axis_tuser
);
    localparam int LW = 2*ADDR_WIDTH;
    localparam int UW = 2*ADDR_WIDTH + NUM_CHANNELS_WIDTH;

    typedef enum logic [1:0] {IDLE, SEND_IMG, SEND_KER, FINISH} state_t;
    typedef struct packed {
        logic                  last;
        logic                  sel;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_t        state, state_nxt;
    logic [LW-1:0] img_len, ker_len, rd_cnt, cur_len, new_img_len, new_ker_len;
    logic [UW-1:0] img_user, ker_user;
    logic          rd_active, rd_sel, rd_last;
    logic          rd_vld, rd_vld_last, rd_vld_sel;
    entry_t        fifo [2];
    entry_t        head;
    logic          wr_ptr, rd_ptr;
    logic [1:0]    count;
    logic          gap, push, pop, accept, img_last_hs, ker_last_hs;

    assign accept      = start && (state == IDLE);
    assign new_img_len = LW'(img_row) * LW'(img_col);
    assign new_ker_len = LW'(ker_row) * LW'(ker_col);
    assign cur_len     = rd_sel ? ker_len : img_len;
    assign rd_last     = (rd_cnt == cur_len - LW'(1));

    assign head          = fifo[rd_ptr];
    assign m_axis_tvalid = (count != 2'd0) && !gap;
    assign m_axis_tdata  = head.data;
    assign m_axis_tlast  = m_axis_tvalid && head.last;
    assign m_axis_tuser  = head.sel ? ker_user : img_user;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign push          = rd_vld;
    assign img_last_hs   = pop && head.last && !head.sel;
    assign ker_last_hs   = pop && head.last && head.sel;

    // A pop in this cycle frees a slot, so it counts as room; otherwise a bubble appears every other beat.
    assign mem_rd_en   = rd_active && ((3'(count) + 3'(rd_vld)) < (3'd2 + 3'(pop)));
    assign mem_rd_sel  = mem_rd_en && rd_sel;
    assign mem_rd_addr = mem_rd_en ? rd_cnt[ADDR_WIDTH-1:0] : '0;

    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) state <= IDLE;
        else               state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = SEND_IMG;
            SEND_IMG: if (img_len == '0 || img_last_hs) state_nxt = SEND_KER;
            SEND_KER: if (ker_len == '0 || ker_last_hs) state_nxt = FINISH;
            FINISH:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == FINISH);
    end

    // Read issue runs ahead of the FSM so kernel reads prefetch behind the image tail.
    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            img_len     <= '0;
            ker_len     <= '0;
            img_user    <= '0;
            ker_user    <= '0;
            rd_cnt      <= '0;
            rd_sel      <= 1'b0;
            rd_active   <= 1'b0;
            rd_vld      <= 1'b0;
            rd_vld_last <= 1'b0;
            rd_vld_sel  <= 1'b0;
        end else begin
            rd_vld      <= mem_rd_en;
            rd_vld_last <= mem_rd_en && rd_last;
            rd_vld_sel  <= rd_sel;
            if (accept) begin
                img_len   <= new_img_len;
                ker_len   <= new_ker_len;
                img_user  <= {img_row, img_col, num_channels};
                ker_user  <= {ker_row, ker_col, num_channels};
                rd_cnt    <= '0;
                rd_sel    <= (new_img_len == '0);
                rd_active <= (new_img_len != '0) || (new_ker_len != '0);
            end else if (mem_rd_en) begin
                if (rd_last) begin
                    rd_cnt <= '0;
                    if (!rd_sel && ker_len != '0) rd_sel    <= 1'b1;
                    else                          rd_active <= 1'b0;
                end else begin
                    rd_cnt <= rd_cnt + LW'(1);
                end
            end
        end
    end

    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            fifo[0] <= '0;
            fifo[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= '{last: rd_vld_last, sel: rd_vld_sel, data: mem_rd_data};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

`ifdef AXIS_LOADER_TENSOR_GAP_EN
    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) gap <= 1'b0;
        else               gap <= img_last_hs && (ker_len != '0);
    end
`else
    assign gap = 1'b0;
`endif

endmodule

// File: tb/tb_axis_tensor_loader.sv
// Directed and randomized jobs checked against a beat-queue reference built from tensor dimensions.
module tb_axis_tensor_loader;
  localparam int AW = 13, DW = 8, CW = 7, UW = 2*AW+CW;
`ifdef AXIS_LOADER_TENSOR_GAP_EN
  localparam int GAP_EXP = 1;
`else
  localparam int GAP_EXP = 0;
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, tready = 1'b0;
  logic [AW-1:0] img_row = '0, img_col = '0, ker_row = '0, ker_col = '0;
  logic [CW-1:0] nc = '0;
  logic busy, done, rd_en, rd_sel, tvalid, tlast;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, tdata;
  logic [UW-1:0] tuser;
  logic [DW-1:0] img_mem [256];
  logic [DW-1:0] ker_mem [256];
  beat_t exp_q[$];
  int passed = 0, total = 0, fails = 0;

  axis_tensor_loader dut (
    .m_axis_aclk(clk), .m_axis_areset(rst), .start(start),
    .img_row(img_row), .img_col(img_col), .ker_row(ker_row), .ker_col(ker_col),
    .num_channels(nc), .busy(busy), .done(done),
    .mem_rd_en(rd_en), .mem_rd_sel(rd_sel), .mem_rd_addr(rd_addr), .mem_rd_data(rd_data),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .m_axis_tuser(tuser)
  );

  always #5 clk = ~clk;

  // Buffer model: data one cycle after the strobe.
  always @(posedge clk) if (rd_en) rd_data <= rd_sel ? ker_mem[rd_addr[7:0]] : img_mem[rd_addr[7:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 64'({busy, done, rd_en, rd_sel, rd_addr, tvalid, tlast, tdata, tuser}), 64'(0));
  endtask

  task automatic build(input int ir, ic, kr, kc, ncv);
    exp_q.delete();
    for (int i = 0; i < ir*ic; i++)
      exp_q.push_back('{d: img_mem[i%256], l: (i == ir*ic-1), u: {AW'(ir), AW'(ic), CW'(ncv)}});
    for (int i = 0; i < kr*kc; i++)
      exp_q.push_back('{d: ker_mem[i%256], l: (i == kr*kc-1), u: {AW'(kr), AW'(kc), CW'(ncv)}});
  endtask

  task automatic run_job(input int ir, ic, kr, kc, ncv, input bit rnd, input int restart_at,
                         input int reset_after);
    int nimg, ntot, beats, dones, first_v, reads, hs, idle, post;
    bit sel1, stall, aborted;
    logic [DW-1:0] pd;
    logic pl;
    logic [UW-1:0] pu;
    beat_t e;
    nimg = ir*ic; ntot = nimg + kr*kc;
    beats = 0; dones = 0; first_v = -1; reads = 0; hs = 0; idle = 0; post = 0;
    sel1 = 0; stall = 0; aborted = 0; pd = '0; pl = 1'b0; pu = '0;
    build(ir, ic, kr, kc, ncv);
    @(posedge clk); #1;
    img_row = AW'(ir); img_col = AW'(ic); ker_row = AW'(kr); ker_col = AW'(kc); nc = CW'(ncv);
    start = 1'b1;
    tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1) chk("busy_after_start", 64'(busy), 64'(1));
      if (rd_en) begin
        if (reads == 0) chk("first_rd_addr", 64'({rd_sel, rd_addr}), 64'({nimg == 0, AW'(0)}));
        reads++;
        if (rd_sel) sel1 = 1;
      end
      if (stall) chk("stall_hold", 64'({tvalid, tlast, tdata, tuser}), 64'({1'b1, pl, pd, pu}));
      if (tvalid && first_v < 0) first_v = cyc;
      if (!tvalid && beats > 0 && beats < ntot) idle++;
      if (tvalid && tready) begin
        hs++;
        if (exp_q.size() == 0) chk("extra_beat", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk($sformatf("beat%0d", beats), 64'({tlast, tuser, tdata}), 64'({e.l, e.u, e.d}));
        end
        beats++;
      end
      if (rd_en) chk("fifo_room", 64'(reads - hs <= 2), 64'(1));
      if (done) dones++;
      stall = tvalid && !tready; pd = tdata; pl = tlast; pu = tuser;
      if (reset_after > 0 && beats == reset_after) begin
        @(posedge clk); #1;
        rst = 1'b1;
        #1 chk_zero("abort_outputs_zero");
        @(posedge clk); #1;
        rst = 1'b0;
        aborted = 1;
        break;
      end
      if (dones > 0 && ++post > 3) break;
      @(posedge clk); #1;
      start = (cyc + 1 == restart_at);
      if (start) begin img_row = 2; img_col = 2; ker_row = 1; ker_col = 1; end
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    start = 1'b0;
    if (aborted) return;
    chk("beat_count", 64'(beats), 64'(ntot));
    chk("beats_left", 64'(exp_q.size()), 64'(0));
    chk("done_count", 64'(dones), 64'(1));
    chk("idle_after_done", 64'(busy), 64'(0));
    if (ntot > 0) chk("first_valid_lat", 64'(first_v >= 0 && first_v <= 3), 64'(1));
    if (kr*kc == 0) chk("sel_never_1", 64'(sel1), 64'(0));
    if (!rnd) chk("idle_beats", 64'(idle), 64'((nimg > 0 && kr*kc > 0) ? GAP_EXP : 0));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      img_mem[i] = DW'($urandom);
      ker_mem[i] = DW'($urandom);
    end
    #1 rst = 1'b1;
    #1 chk_zero("reset_state");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_job(4, 4, 3, 3, 1, 1'b0, -1, 0);     // basic job, tready high
    run_job(4, 4, 3, 3, 1, 1'b1, -1, 0);     // random backpressure
    run_job(4, 4, 3, 3, 1, 1'b0, 6, 0);      // second start ignored
    run_job(4, 4, 0, 3, 1, 1'b0, -1, 0);     // empty kernel
    run_job(4, 4, 3, 3, 1, 1'b0, -1, 7);     // reset after 7th image beat
    run_job(4, 4, 3, 3, 2, 1'b0, -1, 0);     // restart from address 0
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 5),
              $urandom_range(0, 5), $urandom_range(0, 127), 1'($urandom_range(0, 1)), -1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/axis_tensor_loader.md
AXIS_TENSOR_LOADER -- requirements
Module: axis_tensor_loader

Interface
REQ-001 ADDR_WIDTH, 13, width of row/col fields and memory address.
REQ-002 DATA_WIDTH, 8, width of tdata and memory read data.
REQ-003 NUM_CHANNELS_WIDTH, 7, width of the channel-count field.
REQ-004 m_axis_aclk  in  1  single clock; all logic is on its rising edge.
REQ-005 m_axis_areset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to stream one job (image tensor, then kernel tensor).
REQ-007 img_row, img_col, ker_row, ker_col  in  ADDR_WIDTH each  tensor dimensions, sampled on accepted start.
REQ-008 num_channels  in  NUM_CHANNELS_WIDTH  channel count, sampled on accepted start.
REQ-009 busy  out  1  high from the cycle after an accepted start until done.
REQ-010 done  out  1  one-cycle pulse when the job completes.
REQ-011 mem_rd_en  out  1  memory read strobe.
REQ-012 mem_rd_sel  out  1  memory select: 0 = image buffer, 1 = kernel buffer.
REQ-013 mem_rd_addr  out  ADDR_WIDTH  read address.
REQ-014 mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
REQ-015 m_axis_tdata  out  DATA_WIDTH  stream payload.
REQ-016 m_axis_tvalid  out  1  / m_axis_tready  in  1  AXI-Stream handshake.
REQ-017 m_axis_tlast  out  1  marks the last beat of each tensor.
REQ-018 m_axis_tuser  out  2*ADDR_WIDTH+NUM_CHANNELS_WIDTH  {rows, cols, num_channels} of the current tensor.

Function
REQ-019 The FSM SHALL have the states IDLE, SEND_IMG, SEND_KER and FINISH.
REQ-020 IDLE->SEND_IMG on start; start SHALL be ignored when not in IDLE.
REQ-021 Tensor length SHALL be rows*cols beats; addresses SHALL run 0..len-1 in order.
REQ-022 A zero-length tensor SHALL be skipped, with no beats and no tlast.
REQ-023 SEND_IMG->SEND_KER after the image tlast handshake; SEND_KER->FINISH after the kernel tlast handshake; FINISH->IDLE after 1 cycle with done=1.
REQ-024 Read data SHALL pass through a 2-entry skid FIFO.
REQ-025 mem_rd_en SHALL assert only when FIFO occupancy plus in-flight reads is below 2, so no data is ever dropped.
REQ-026 The first tvalid SHALL assert no later than 3 cycles after the start cycle.
REQ-027 With tready held high, one beat SHALL transfer per cycle with no bubbles, except as allowed by REQ-034.
REQ-028 While tvalid=1 and tready=0, tdata, tlast and tuser SHALL stay stable and tvalid SHALL stay high.
REQ-029 tuser SHALL be constant for every beat of a tensor.
REQ-030 Length and address arithmetic SHALL be at least 2*ADDR_WIDTH bits wide.
REQ-031 A product that does not fit in ADDR_WIDTH address bits is a caller error; the block SHALL still terminate after len beats.

Reset
REQ-032 On m_axis_areset, immediately and regardless of clock:
- FSM to IDLE; FIFO emptied; in-flight reads discarded;
- busy, done, mem_rd_en, mem_rd_sel, mem_rd_addr, m_axis_tvalid, m_axis_tlast, m_axis_tdata and m_axis_tuser all 0.
REQ-033 Reset mid-stream SHALL abort the job; the next start after reset deassertion SHALL restart from image address 0.

Configuration
REQ-034 Macro AXIS_LOADER_TENSOR_GAP_EN:
- Defined: exactly one cycle with tvalid=0 SHALL follow the image tlast handshake before the first kernel beat.
- Undefined: the kernel's first beat MAY follow the image tlast in the next cycle.

Verification
REQ-035 img 4x4, ker 3x3, ch=1, tready=1:
- 16 beats with tdata = image mem[0..15], tlast on beat 16, tuser={4,4,1};
- then 9 kernel beats, tlast on beat 9, tuser={3,3,1};
- done pulses once.
REQ-036 Same job with tready toggled pseudo-randomly (50%):
- identical beat sequence;
- no data change while tvalid=1 and tready=0;
- mem reads never exceed FIFO room.
REQ-037 Second start pulse during SEND_IMG -> ignored; exactly one job of 25 beats and a single done pulse.
REQ-038 ker 0x3 -> 16 image beats only, then done; mem_rd_sel never 1.
REQ-039 Reset asserted after the 7th image beat -> all outputs 0 in the same cycle; after a new start, the stream begins at image address 0.
REQ-040 With AXIS_LOADER_TENSOR_GAP_EN defined and tready=1 -> exactly one tvalid=0 cycle between beat 16 and beat 17; undefined -> zero idle cycles.
